// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard decoder.
//   PS2_EXT_PREFIX   - scan-code prefix marking an extended key
//   PS2_BREAK_PREFIX - scan-code prefix marking a key release
//   frame_state_e    - PS/2 frame receiver states
package ps2_pkg;
  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: brings the raw PS/2 clock and data lines into the clk
// domain and flags falling edges of the keyboard clock.
// Ports:
//   clk, reset      - system clock, async active-low reset
//   ps2_clk         - raw keyboard clock (asynchronous)
//   ps2_data        - raw keyboard data (asynchronous)
//   data_s          - synchronized data, valid to sample when fall=1
//   fall            - one-cycle strobe: synced ps2_clk went 1 -> 0
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;

  // Everything resets to the bus idle level (high) so releasing reset
  // while the lines idle never looks like a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign data_s = data_sync[1];
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: receives PS/2 keyboard frames (start, 8 data LSB first,
// parity, stop) and turns scan-code sequences into key events.
// 0xE0 marks an extended key and 0xF0 a release; both are absorbed and
// reported on the following code byte.
// Ports:
//   clk, reset  - system clock, async active-low reset
//   ps2_clk     - raw keyboard clock
//   ps2_data    - raw keyboard data
//   valid       - one-cycle pulse per key event
//   makeBreak   - 1 = press, 0 = release (held between events)
//   outCode     - scan code with prefixes stripped (held between events)
//   extended    - event carried the 0xE0 prefix (held between events)
//   frame_err   - one-cycle pulse per discarded frame (bad stop/timeout,
//                 bad parity when checking is enabled)
// Parameter:
//   TIMEOUT_CYCLES - clk cycles without a ps2_clk fall before a partial
//                    frame is abandoned
// Build option:
//   PS2_PARITY_CHECK_EN - when defined, frames must have odd parity over
//                         data+parity bit; otherwise the parity bit is ignored.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       valid,
  output logic       makeBreak,
  output logic [7:0] outCode,
  output logic       extended,
  output logic       frame_err
);
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  logic data_s, fall;

  ps2_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_s   (data_s),
    .fall     (fall)
  );

  frame_state_e    state, state_nxt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [TO_W-1:0] to_cnt;
  logic            ext, brk;
  logic            byte_done, frame_bad, timeout, par_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      par_bit <= 1'b0;
    else if (fall && state == PARITY) par_bit <= data_s;
  end

  assign par_ok = ^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  // ---------------- frame FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    // A fall in the timeout cycle still counts as activity.
    timeout   = (state != IDLE) && !fall && (to_cnt == TO_MAX);
    if (timeout) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_s) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          if (data_s && par_ok) byte_done = 1'b1;
          else                  frame_bad = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bit counter and shifter; the counter is held at 0 in IDLE so an
  // abandoned frame never leaks a stale count into the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else if (state == IDLE) begin
      bit_cnt <= 3'd0;
    end else if (fall && state == DATA) begin
      bit_cnt <= bit_cnt + 3'd1;
      shreg   <= {data_s, shreg[7:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      to_cnt <= '0;
    else if (state == IDLE || fall)  to_cnt <= '0;
    else if (to_cnt != TO_MAX)       to_cnt <= to_cnt + 1'b1;
  end

  // ---------------- decode stage ----------------
  // Events are registered on the same edge that consumes the stop bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      makeBreak <= 1'b0;
      outCode   <= 8'h00;
      extended  <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= frame_bad | timeout;
      if (frame_bad || timeout) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_done) begin
        if (shreg == PS2_EXT_PREFIX) begin
          ext <= 1'b1;
        end else if (shreg == PS2_BREAK_PREFIX) begin
          brk <= 1'b1;
        end else begin
          valid     <= 1'b1;
          outCode   <= shreg;
          makeBreak <= ~brk;
          extended  <= ext;
          ext       <= 1'b0;
          brk       <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
`timescale 1ns/1ps
module tb_ps2_key_decoder;
  localparam int TO   = 200;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       valid, makeBreak, extended, frame_err;
  logic [7:0] outCode;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .valid     (valid),
    .makeBreak (makeBreak),
    .outCode   (outCode),
    .extended  (extended),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // event monitor, sampled on the falling clk edge
  int         nvalid = 0, nerr = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_mb = 1'b0, last_ext = 1'b0;
  int         lat = 0;

  always @(negedge clk) begin
    if (valid) begin
      nvalid++;
      last_code = outCode;
      last_mb   = makeBreak;
      last_ext  = extended;
    end
    if (frame_err) nerr++;
    if (valid && frame_err) begin
      n_fail++;
      $display("FAIL excl: valid and frame_err both high at %0t", $time);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set during the high phase, then clock low.
  // lat records how many clk edges after the falling edge valid shows up.
  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clk);
      if (valid && lat == 0) lat = i;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] b, input logic par, input logic stp);
    lat = 0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stp);
    ps2_data = 1'b1;
    idle(2 * HALF);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_raw(b, ~^b, 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({valid, makeBreak, outCode, extended, frame_err} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 000000000000",
               {valid, makeBreak, outCode, extended, frame_err});
    end
    idle(3);
    reset = 1'b1;
    idle(20);
    n_checks++;
    if (nvalid !== 0 || nerr !== 0) begin
      n_fail++;
      $display("FAIL reset_release: valid=%0d err=%0d want 0 0", nvalid, nerr);
    end
  endtask

  task automatic test_make;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_frame(8'h1D);
    n_checks++;
    if (nvalid - v0 !== 1 || nerr !== e0 || last_code !== 8'h1D || last_mb !== 1'b1 || last_ext !== 1'b0) begin
      n_fail++;
      $display("FAIL make_1D: nv=%0d ne=%0d code=%h mb=%b ext=%b want 1 0 1d 1 0",
               nvalid - v0, nerr - e0, last_code, last_mb, last_ext);
    end
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL latency: got %0d want 3", lat);
    end
    idle(10);
    n_checks++;
    if (outCode !== 8'h1D || makeBreak !== 1'b1 || extended !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: code=%h mb=%b ext=%b v=%b want 1d 1 0 0", outCode, makeBreak, extended, valid);
    end
  endtask

  task automatic test_break;
    int v0;
    v0 = nvalid;
    send_frame(8'hF0);
    n_checks++;
    if (nvalid !== v0) begin
      n_fail++;
      $display("FAIL break_prefix: nv=%0d want 0", nvalid - v0);
    end
    send_frame(8'h1D);
    n_checks++;
    if (nvalid - v0 !== 1 || last_code !== 8'h1D || last_mb !== 1'b0 || last_ext !== 1'b0) begin
      n_fail++;
      $display("FAIL break_1D: nv=%0d code=%h mb=%b ext=%b want 1 1d 0 0",
               nvalid - v0, last_code, last_mb, last_ext);
    end
  endtask

  task automatic test_extended;
    int v0;
    v0 = nvalid;
    send_frame(8'hE0);
    send_frame(8'h75);
    n_checks++;
    if (nvalid - v0 !== 1 || last_code !== 8'h75 || last_mb !== 1'b1 || last_ext !== 1'b1) begin
      n_fail++;
      $display("FAIL ext_make: nv=%0d code=%h mb=%b ext=%b want 1 75 1 1",
               nvalid - v0, last_code, last_mb, last_ext);
    end
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    n_checks++;
    if (nvalid - v0 !== 2 || last_code !== 8'h75 || last_mb !== 1'b0 || last_ext !== 1'b1) begin
      n_fail++;
      $display("FAIL ext_break: nv=%0d code=%h mb=%b ext=%b want 2 75 0 1",
               nvalid - v0, last_code, last_mb, last_ext);
    end
    send_frame(8'h1C);
    n_checks++;
    if (last_code !== 8'h1C || last_mb !== 1'b1 || last_ext !== 1'b0) begin
      n_fail++;
      $display("FAIL flags_clear: code=%h mb=%b ext=%b want 1c 1 0", last_code, last_mb, last_ext);
    end
  endtask

  task automatic test_idle_high;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_bit(1'b1);
    idle(2 * HALF);
    send_frame(8'h16);
    n_checks++;
    if (nerr !== e0 || nvalid - v0 !== 1 || last_code !== 8'h16) begin
      n_fail++;
      $display("FAIL idle_high: ne=%0d nv=%0d code=%h want 0 1 16", nerr - e0, nvalid - v0, last_code);
    end
  endtask

  task automatic test_stop_err;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_frame(8'hF0);
    send_raw(8'h1D, 1'b1, 1'b0);
    n_checks++;
    if (nvalid !== v0 || nerr - e0 !== 1) begin
      n_fail++;
      $display("FAIL stop_err: nv=%0d ne=%0d want 0 1", nvalid - v0, nerr - e0);
    end
    send_frame(8'h1D);
    n_checks++;
    if (nvalid - v0 !== 1 || last_mb !== 1'b1 || last_code !== 8'h1D) begin
      n_fail++;
      $display("FAIL stop_err_clear: nv=%0d mb=%b code=%h want 1 1 1d", nvalid - v0, last_mb, last_code);
    end
  endtask

  task automatic test_parity;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_raw(8'h1D, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    n_checks++;
    if (nvalid !== v0 || nerr - e0 !== 1) begin
      n_fail++;
      $display("FAIL parity_bad: nv=%0d ne=%0d want 0 1", nvalid - v0, nerr - e0);
    end
    send_frame(8'h1C);
    n_checks++;
    if (nvalid - v0 !== 1 || last_code !== 8'h1C) begin
      n_fail++;
      $display("FAIL parity_next: nv=%0d code=%h want 1 1c", nvalid - v0, last_code);
    end
`else
    n_checks++;
    if (nvalid - v0 !== 1 || nerr !== e0 || last_code !== 8'h1D) begin
      n_fail++;
      $display("FAIL parity_ignored: nv=%0d ne=%0d code=%h want 1 0 1d", nvalid - v0, nerr - e0, last_code);
    end
`endif
  endtask

  // start + 4 data bits, then the clock stays high until frame_err
  task automatic partial_timeout(input string tag);
    int k, e0;
    e0 = nerr;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk);
    ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    k = 0;
    for (int i = 1; i <= TO + 50; i++) begin
      @(negedge clk);
      if (i == HALF) ps2_clk = 1'b1;
      if (frame_err && k == 0) k = i;
    end
    ps2_data = 1'b1;
    n_checks++;
    if (k !== TO + 3 || nerr - e0 !== 1) begin
      n_fail++;
      $display("FAIL timeout_%s: err at %0d (count %0d) want %0d (count 1)", tag, k, nerr - e0, TO + 3);
    end
  endtask

  task automatic test_timeout;
    int v0;
    v0 = nvalid;
    send_frame(8'hF0);
    partial_timeout("a");
    send_frame(8'h1D);
    n_checks++;
    if (nvalid - v0 !== 1 || last_mb !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_clears_brk: nv=%0d mb=%b want 1 1", nvalid - v0, last_mb);
    end
    partial_timeout("b");
    send_frame(8'hF0);
    idle(50);
    send_frame(8'h1D);
    n_checks++;
    if (nvalid - v0 !== 2 || last_mb !== 1'b0 || last_code !== 8'h1D) begin
      n_fail++;
      $display("FAIL brk_after_timeout: nv=%0d mb=%b code=%h want 2 0 1d", nvalid - v0, last_mb, last_code);
    end
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    logic [7:0] b;
    b = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b[i]);
    @(negedge clk);
    ps2_data = b[5];
    idle(3);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({valid, makeBreak, outCode, extended, frame_err} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_outs: got %b want 000000000000",
               {valid, makeBreak, outCode, extended, frame_err});
    end
    idle(3);
    reset = 1'b1;
    ps2_data = 1'b1;
    v0 = nvalid; e0 = nerr;
    idle(TO + 20);
    n_checks++;
    if (nvalid !== v0 || nerr !== e0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: nv=%0d ne=%0d want 0 0", nvalid - v0, nerr - e0);
    end
    send_frame(8'h29);
    n_checks++;
    if (nvalid - v0 !== 1 || last_code !== 8'h29 || last_mb !== 1'b1 || last_ext !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_next: nv=%0d code=%h mb=%b ext=%b want 1 29 1 0",
               nvalid - v0, last_code, last_mb, last_ext);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_idle_high();
    test_stop_err();
    test_parity();
    test_timeout();
    test_reset_mid();
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
